// File: rtl/fb_pkg.sv
// Shared definitions for the monochrome double-buffered frame buffer.
//   fbMode_t       : per-frame pixel conversion mode
//   R/G/B_MSB/LSB  : 4-bit nibble positions taken from an RGB565 word
//   clog2()        : elaboration-time address width helper
package fb_pkg;

   typedef enum logic [1:0] {
      MODE_GREY = 2'd0,
      MODE_RED  = 2'd1,
      MODE_BIN  = 2'd2,
      MODE_RCH  = 2'd3
   } fbMode_t;

   // Top four bits of each RGB565 channel (the green LSB pair and the
   // red/blue LSB are dropped).
   localparam int R_MSB = 15;
   localparam int R_LSB = 12;
   localparam int G_MSB = 10;
   localparam int G_LSB = 7;
   localparam int B_MSB = 4;
   localparam int B_LSB = 1;

   function automatic int clog2(input int value);
      int result;
      result = 0;
      while ((1 << result) < value) result++;
      return result;
   endfunction

endpackage

// File: rtl/fb_bram_dp.sv
// Simple dual-port RAM: one write port, one read port, registered read
// (one cycle). No reset on the array so it maps onto block RAM.
//   clk     : clock
//   wrEn    : write enable
//   wrAddr  : write address
//   wrData  : write data
//   rdAddr  : read address
//   rdData  : read data, valid one cycle after rdAddr
module fb_bram_dp #(
   parameter int DEPTH = 2,
   parameter int AW    = 1,
   parameter int DW    = 4
) (
   input  logic          clk,
   input  logic          wrEn,
   input  logic [AW-1:0] wrAddr,
   input  logic [DW-1:0] wrData,
   input  logic [AW-1:0] rdAddr,
   output logic [DW-1:0] rdData
);

   logic [DW-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (wrEn) mem[wrAddr] <= wrData;
      rdData <= mem[rdAddr];
   end

endmodule

// File: rtl/frame_buffer_mono_db.sv
// Double-buffered monochrome frame buffer. Camera pixels (RGB565) inside a
// capture window are converted to a PIX_BITS intensity and written to the
// write bank; the read side always sees the other, complete bank.
//   clk, reset        : clock, synchronous active-high reset
//   mode              : conversion mode, latched on frameDone
//   inX/inY/inPixel   : write-side coordinate and RGB565 data
//   pixelValid        : write strobe
//   frameDone         : end-of-frame pulse, swaps banks
//   outX/outY         : read-side coordinate
//   outPixel/outValid : read data, 3 cycles after outX/outY
//   rdBank            : bank presented to the read side
module frame_buffer_mono_db
   import fb_pkg::*;
#(
   parameter int IMG_W    = 600,
   parameter int IMG_H    = 400,
   parameter int X_OFF    = 20,
   parameter int Y_OFF    = 40,
   parameter int PIX_BITS = 4,
   parameter int RED_MIN  = 8,
   parameter int GB_MAX   = 7,
   parameter int HUE_VAL  = 8,
   parameter int BIN_THR  = 8
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [1:0]          mode,
   input  logic [9:0]          inX,
   input  logic [8:0]          inY,
   input  logic [15:0]         inPixel,
   input  logic                pixelValid,
   input  logic                frameDone,
   input  logic [9:0]          outX,
   input  logic [8:0]          outY,
   output logic [PIX_BITS-1:0] outPixel,
   output logic                outValid,
   output logic                rdBank
);

   localparam int FRAME  = IMG_W * IMG_H;
   localparam int ADDR_W = clog2(FRAME);
   // One extra bit selects the bank; bank 1 sits at offset FRAME so the
   // RAM depth stays exactly two frames even when FRAME is not a power of 2.
   localparam int RAM_AW = ADDR_W + 1;

   function automatic logic [RAM_AW-1:0] physAddr(input logic bank,
                                                  input logic [ADDR_W-1:0] local_a);
      return bank ? RAM_AW'(local_a) + RAM_AW'(FRAME) : RAM_AW'(local_a);
   endfunction

   fbMode_t modeLat;
   logic    wrBank;

   // ---------------- write side ----------------
   logic [31:0]         inX32, inY32;
   logic                inWin;
   logic [ADDR_W-1:0]   wrLocal;
   logic [3:0]          rNib, gNib, bNib;
   logic [5:0]          rgbSum;
   logic [3:0]          grey;
   logic [3:0]          p4;

   logic                s1Valid;
   logic                s1Bank;
   logic [ADDR_W-1:0]   s1Addr;
   logic [PIX_BITS-1:0] s1Data;

   assign inX32 = 32'(inX);
   assign inY32 = 32'(inY);
   assign inWin = (inX32 >= 32'(X_OFF)) && (inX32 < 32'(X_OFF + IMG_W)) &&
                  (inY32 >= 32'(Y_OFF)) && (inY32 < 32'(Y_OFF + IMG_H));
   assign wrLocal = ADDR_W'((inX32 - 32'(X_OFF)) + (inY32 - 32'(Y_OFF)) * 32'(IMG_W));

   assign rNib   = inPixel[R_MSB:R_LSB];
   assign gNib   = inPixel[G_MSB:G_LSB];
   assign bNib   = inPixel[B_MSB:B_LSB];
   assign rgbSum = {2'b00, rNib} + {2'b00, gNib} + {2'b00, bNib};
   assign grey   = 4'(rgbSum / 6'd3);

   logic unusedPixelBits;
   assign unusedPixelBits = &{1'b0, inPixel[11], inPixel[6:5], inPixel[0]};

   always_comb begin
      p4 = '0;
      unique case (modeLat)
         MODE_GREY: p4 = grey;
         MODE_RED:  p4 = ((rNib >= 4'(RED_MIN)) && (gNib < 4'(GB_MAX)) &&
                          (bNib < 4'(GB_MAX))) ? 4'(HUE_VAL) : 4'h0;
         MODE_BIN:  p4 = (grey >= 4'(BIN_THR)) ? 4'hF : 4'h0;
         MODE_RCH:  p4 = rNib;
         default:   p4 = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         modeLat <= MODE_GREY;
         wrBank  <= 1'b0;
         rdBank  <= 1'b1;
         s1Valid <= 1'b0;
      end else begin
         if (frameDone) begin
            modeLat <= fbMode_t'(mode);
            wrBank  <= ~wrBank;
            rdBank  <= ~rdBank;
         end
         s1Valid <= pixelValid && inWin;
      end
   end

   // Stage 1 captures the bank bit so a pixel in the frameDone cycle still
   // lands in the frame it belongs to.
   always_ff @(posedge clk) begin
      s1Bank <= wrBank;
      s1Addr <= wrLocal;
      s1Data <= PIX_BITS'(p4 >> (4 - PIX_BITS));
   end

   // ---------------- read side ----------------
   logic [31:0]         outX32, outY32;
   logic                rdInWin;
   logic [ADDR_W-1:0]   rdLocal;
   logic [RAM_AW-1:0]   rdAddr1;
   logic                rdWin1, rdWin2;
   logic [PIX_BITS-1:0] ramQ;

   assign outX32  = 32'(outX);
   assign outY32  = 32'(outY);
   assign rdInWin = (outX32 >= 32'(X_OFF)) && (outX32 < 32'(X_OFF + IMG_W)) &&
                    (outY32 >= 32'(Y_OFF)) && (outY32 < 32'(Y_OFF + IMG_H));
   assign rdLocal = ADDR_W'((outX32 - 32'(X_OFF)) + (outY32 - 32'(Y_OFF)) * 32'(IMG_W));

   // Out-of-window reads are parked on address 0 so the RAM index never
   // runs past the array; their data is masked at c3 anyway.
   always_ff @(posedge clk) begin
      rdAddr1 <= rdInWin ? physAddr(rdBank, rdLocal) : '0;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rdWin1   <= 1'b0;
         rdWin2   <= 1'b0;
         outValid <= 1'b0;
         outPixel <= '0;
      end else begin
         rdWin1   <= rdInWin;
         rdWin2   <= rdWin1;
         outValid <= rdWin2;
         outPixel <= rdWin2 ? ramQ : '0;
      end
   end

   // A write still in stage 1 when reset arrives is dropped.
   fb_bram_dp #(
      .DEPTH(2 * FRAME),
      .AW   (RAM_AW),
      .DW   (PIX_BITS)
   ) uRam (
      .clk   (clk),
      .wrEn  (s1Valid && !reset),
      .wrAddr(physAddr(s1Bank, s1Addr)),
      .wrData(s1Data),
      .rdAddr(rdAddr1),
      .rdData(ramQ)
   );

endmodule

// File: tb/tb_frame_buffer_mono_db.sv
// Bench for frame_buffer_mono_db: a 4-bit and a 1-bit build share all
// stimulus; a behavioural model (sparse memory per bank, pending write,
// 3-deep expectation queue) predicts every read result.
module tb_frame_buffer_mono_db;

   localparam int IMG_W = 600;
   localparam int IMG_H = 400;
   localparam int X_OFF = 20;
   localparam int Y_OFF = 40;
   localparam int FRAME = IMG_W * IMG_H;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset;
   logic [1:0]  mode;
   logic [9:0]  inX, outX;
   logic [8:0]  inY, outY;
   logic [15:0] inPixel;
   logic        pixelValid, frameDone;
   logic [3:0]  out4;
   logic [0:0]  out1;
   logic        val4, val1, rb4, rb1;

   frame_buffer_mono_db dut4 (
      .clk(clk), .reset(reset), .mode(mode), .inX(inX), .inY(inY),
      .inPixel(inPixel), .pixelValid(pixelValid), .frameDone(frameDone),
      .outX(outX), .outY(outY), .outPixel(out4), .outValid(val4), .rdBank(rb4)
   );

   frame_buffer_mono_db #(.PIX_BITS(1)) dut1 (
      .clk(clk), .reset(reset), .mode(mode), .inX(inX), .inY(inY),
      .inPixel(inPixel), .pixelValid(pixelValid), .frameDone(frameDone),
      .outX(outX), .outY(outY), .outPixel(out1), .outValid(val1), .rdBank(rb1)
   );

   int nVec = 0;
   int nErr = 0;

   // model state
   logic [3:0] mdl [int];
   logic       mRd, mWr;
   logic [1:0] mMode;
   logic       pend;
   int         pKey;
   logic [3:0] pVal;

   typedef struct {
      logic       v;
      logic [3:0] p;
      logic       chk;
   } exp_t;
   exp_t q[$];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
      nVec++;
      assert (got === exp)
      else begin
         nErr++;
         $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   function automatic bit inWin(input int x, input int y);
      return x >= X_OFF && x < X_OFF + IMG_W && y >= Y_OFF && y < Y_OFF + IMG_H;
   endfunction

   function automatic int key(input logic bank, input int x, input int y);
      return (bank ? FRAME : 0) + (x - X_OFF) + (y - Y_OFF) * IMG_W;
   endfunction

   function automatic logic [3:0] conv(input logic [1:0] m, input logic [15:0] px);
      int r, g, b, gr;
      r  = int'(px[15:12]);
      g  = int'(px[10:7]);
      b  = int'(px[4:1]);
      gr = (r + g + b) / 3;
      case (m)
         2'd0:    return 4'(gr);
         2'd1:    return (r >= 8 && g < 7 && b < 7) ? 4'd8 : 4'd0;
         2'd2:    return (gr >= 8) ? 4'hF : 4'h0;
         default: return 4'(r);
      endcase
   endfunction

   function automatic logic [15:0] mk(input int r, input int g, input int b);
      logic [15:0] f;
      f = 16'($urandom) & 16'h0861;
      return 16'((r << 12) | (g << 7) | (b << 1)) | f;
   endfunction

   task automatic cyc(input bit rst, input bit wv, input int wx, input int wy,
                      input logic [15:0] wp, input bit fd, input int rx, input int ry);
      exp_t e, f;
      if (pend && !rst) mdl[pKey] = pVal;
      pend = 1'b0;
      if (rst) e = '{1'b0, 4'h0, 1'b1};
      else if (inWin(rx, ry)) begin
         if (mdl.exists(key(mRd, rx, ry))) e = '{1'b1, mdl[key(mRd, rx, ry)], 1'b1};
         else e = '{1'b1, 4'h0, 1'b0};
      end else e = '{1'b0, 4'h0, 1'b1};
      if (!rst && wv && inWin(wx, wy)) begin
         pend = 1'b1;
         pKey = key(mWr, wx, wy);
         pVal = conv(mMode, wp);
      end
      reset      = rst;
      pixelValid = wv;
      inX        = 10'(wx);
      inY        = 9'(wy);
      inPixel    = wp;
      frameDone  = fd;
      outX       = 10'(rx);
      outY       = 9'(ry);
      tick();
      if (rst) begin
         mRd = 1'b1; mWr = 1'b0; mMode = 2'd0;
         foreach (q[i]) q[i] = '{1'b0, 4'h0, 1'b1};
      end else if (fd) begin
         mRd = ~mRd; mWr = ~mWr; mMode = mode;
      end
      q.push_back(e);
      if (q.size() >= 3) begin
         f = q.pop_front();
         check("outValid4", {3'b0, val4}, {3'b0, f.v});
         check("outValid1", {3'b0, val1}, {3'b0, f.v});
         if (f.chk) begin
            check("outPixel4", out4, f.p);
            check("outPixel1", {3'b0, out1}, f.p >> 3);
         end
      end
      check("rdBank4", {3'b0, rb4}, {3'b0, mRd});
      check("rdBank1", {3'b0, rb1}, {3'b0, mRd});
   endtask

   task automatic wr(input int x, input int y, input logic [15:0] p);
      cyc(0, 1, x, y, p, 0, 0, 0);
   endtask
   task automatic rd(input int x, input int y);
      cyc(0, 0, 0, 0, 16'h0, 0, x, y);
   endtask
   task automatic fdp();
      cyc(0, 0, 0, 0, 16'h0, 1, 0, 0);
   endtask
   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 16'h0, 0, 0, 0);
   endtask

   function automatic int pickX();
      return ($urandom_range(0, 1) != 0) ? int'($urandom_range(X_OFF - 1, X_OFF + 2))
                                         : int'($urandom_range(X_OFF + IMG_W - 3, X_OFF + IMG_W));
   endfunction
   function automatic int pickY();
      return ($urandom_range(0, 1) != 0) ? int'($urandom_range(Y_OFF - 1, Y_OFF + 1))
                                         : int'($urandom_range(Y_OFF + IMG_H - 2, Y_OFF + IMG_H));
   endfunction

   initial begin
      reset = 1'b1; mode = 2'd0; inX = '0; inY = '0; inPixel = '0;
      pixelValid = 1'b0; frameDone = 1'b0; outX = '0; outY = '0;
      mRd = 1'b1; mWr = 1'b0; mMode = 2'd0; pend = 1'b0; pKey = 0; pVal = '0;
      tick();
      frameDone = 1'b1;   // ignored while reset is high
      tick();
      frameDone = 1'b0;
      check("rst_outPixel4", out4, 4'h0);
      check("rst_outValid4", {3'b0, val4}, 4'h0);
      check("rst_rdBank4", {3'b0, rb4}, 4'h1);
      check("rst_outPixel1", {3'b0, out1}, 4'h0);
      check("rst_outValid1", {3'b0, val1}, 4'h0);
      check("rst_rdBank1", {3'b0, rb1}, 4'h1);
      q.push_back('{1'b0, 4'h0, 1'b1});
      q.push_back('{1'b0, 4'h0, 1'b1});

      // grey average, first window pixel, exact 3-cycle latency
      wr(20, 40, 16'hF7BE);
      fdp();
      rd(20, 40);
      idle(3);

      // red hue at the last window pixel and just outside it
      mode = 2'd1;
      fdp();
      wr(619, 439, mk(9, 2, 3));
      wr(618, 439, mk(9, 7, 3));
      wr(620, 439, mk(9, 2, 3));
      wr(619, 440, mk(9, 2, 3));
      fdp();
      rd(619, 439);
      rd(618, 439);
      rd(620, 439);
      rd(619, 440);
      idle(3);

      // ping-pong: frame A = 3, frame B = 5 written while A is read
      mode = 2'd3;
      fdp();
      for (int i = 0; i < 8; i++) wr(300 + i, 200, mk(3, 0, 0));
      fdp();
      for (int i = 0; i < 8; i++) cyc(0, 1, 300 + i, 200, mk(5, 0, 0), 0, 300 + i, 200);
      cyc(0, 0, 0, 0, 16'h0, 1, 300, 200);
      for (int i = 0; i < 8; i++) rd(300 + i, 200);
      idle(3);

      // mode change mid-frame only applies after the next frameDone
      mode = 2'd0;
      fdp();
      wr(100, 100, mk(12, 1, 1));
      mode = 2'd1;
      wr(101, 100, mk(12, 1, 1));
      fdp();
      rd(100, 100);
      rd(101, 100);
      wr(102, 100, mk(12, 1, 1));
      fdp();
      rd(102, 100);
      idle(3);

      // binary threshold (1-bit build sees 0/1)
      mode = 2'd2;
      fdp();
      wr(200, 100, mk(7, 7, 7));
      wr(201, 100, mk(8, 8, 8));
      fdp();
      rd(200, 100);
      rd(201, 100);
      idle(3);

      // reset with a write in flight and another presented during reset
      mode = 2'd0;
      cyc(1, 0, 0, 0, 16'h0, 0, 0, 0);
      wr(30, 50, mk(6, 6, 6));
      fdp();
      fdp();
      cyc(0, 1, 30, 50, mk(12, 12, 12), 0, 20, 40);
      cyc(1, 1, 30, 50, mk(3, 3, 3), 1, 20, 40);
      idle(1);
      fdp();
      rd(30, 50);
      idle(3);

      // randomized traffic around the window edges
      for (int i = 0; i < 400; i++) begin
         mode = 2'($urandom_range(0, 3));
         cyc(0, $urandom_range(0, 1) != 0, pickX(), pickY(), 16'($urandom),
             $urandom_range(0, 15) == 0, pickX(), pickY());
      end
      idle(3);

      $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
      $finish;
   end

endmodule
